mem_bist_ctrl: RTL and testbench

//  Parametrised memory self-test controller for the frame-buffer / RAM port interface.

---
 rtl/mem_bist_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_ctrl.sv
// Memory self-test controller: writes a pattern over an address window,
// reads it back with bounded outstanding reads, and reports pass/fail.
module mem_bist_ctrl #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 24,
    parameter logic [DATA_W-1:0] CMP_MASK  = DATA_W'(32'hFFFFFF),
    parameter int unsigned       MAX_OUTST = 8,
    parameter int unsigned       TIMEOUT   = 1024,
    parameter int unsigned       ERR_W     = 16
) (
    input  logic              CLOCK_125_p,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] tst_patt,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    output logic              wr_en,
    input  logic              wr_rdy,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    input  logic              rd_rdy,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_data_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int unsigned OW = $clog2(MAX_OUTST + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] DW_A = ADDR_W'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE
    } state_t;

    state_t state, state_n;

    logic [1:0]        cfg_mode;
    logic [DATA_W-1:0] cfg_patt;
    logic [ADDR_W-1:0] cfg_base, cfg_n;
    logic [ADDR_W-1:0] wcnt, rcnt, vcnt;
    logic [OW-1:0]     outst;
    logic [TW-1:0]     wdog;

    logic              start_ok, wr_fire, rd_fire, chk, miscmp, wd_run, wd_hit;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;

    // Index is the offset from the window base, so walk-1 restarts at bit 0 there.
    function automatic logic [DATA_W-1:0] gen(
        input logic [1:0]        m,
        input logic [DATA_W-1:0] p,
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] i
    );
        logic [DATA_W-1:0] z;
        z = DATA_W'(a);
        unique case (m)
            2'd0:    gen = p;
            2'd1:    gen = z;
            2'd2:    gen = {{(DATA_W-1){1'b0}}, 1'b1} << (i % DW_A);
            default: gen = ~z;
        endcase
    endfunction

    assign wr_addr  = cfg_base + wcnt;
    assign rd_addr  = cfg_base + rcnt;
    assign exp_addr = cfg_base + vcnt;
    assign wr_data  = gen(cfg_mode, cfg_patt, wr_addr, wcnt);
    assign exp_data = gen(cfg_mode, cfg_patt, exp_addr, vcnt);

    assign wr_en    = (state == S_WRITE);
    assign rd_en    = (state == S_READ) && (rcnt != cfg_n)
                   && (outst < OW'(MAX_OUTST));
    assign busy     = (state == S_WRITE) || (state == S_READ)
                   || (state == S_DRAIN);
    assign done     = (state == S_DONE);

    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
    assign wr_fire  = wr_en && wr_rdy;
    assign rd_fire  = rd_en && rd_rdy;
    assign chk      = rd_data_valid && (outst != '0)
                   && ((state == S_READ) || (state == S_DRAIN));
    assign miscmp   = chk && (((rd_data ^ exp_data) & CMP_MASK) != '0);
    assign wd_run   = ((state == S_READ) || (state == S_DRAIN))
                   && (outst != '0) && !chk;
    assign wd_hit   = wd_run && (wdog == TW'(TIMEOUT - 1));

    always_ff @(posedge CLOCK_125_p or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE, S_DONE:
                if (start) state_n = (num_words == '0) ? S_DONE : S_WRITE;
            S_WRITE:
                if (wr_fire && (wcnt + ADDR_W'(1) == cfg_n)) state_n = S_READ;
            S_READ:
                if (rd_fire && (rcnt + ADDR_W'(1) == cfg_n)) state_n = S_DRAIN;
            S_DRAIN:
                if (vcnt == cfg_n) state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
        if (wd_hit) state_n = S_DONE;
    end

    always_ff @(posedge CLOCK_125_p or negedge reset) begin
        if (!reset) begin
            cfg_mode       <= '0;
            cfg_patt       <= '0;
            cfg_base       <= '0;
            cfg_n          <= '0;
            wcnt           <= '0;
            rcnt           <= '0;
            vcnt           <= '0;
            outst          <= '0;
            wdog           <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            fail           <= 1'b0;
            pass           <= 1'b0;
        end else if (start_ok) begin
            cfg_mode       <= mode;
            cfg_patt       <= tst_patt;
            cfg_base       <= base_addr;
            cfg_n          <= num_words;
            wcnt           <= '0;
            rcnt           <= '0;
            vcnt           <= '0;
            outst          <= '0;
            wdog           <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            fail           <= 1'b0;
            pass           <= (num_words == '0);
        end else begin
            if (wr_fire) wcnt <= wcnt + ADDR_W'(1);
            if (rd_fire) rcnt <= rcnt + ADDR_W'(1);
            if (chk)     vcnt <= vcnt + ADDR_W'(1);
            unique case ({rd_fire, chk})
                2'b10:   outst <= outst + OW'(1);
                2'b01:   outst <= outst - OW'(1);
                default: outst <= outst;
            endcase
            if (wd_run) wdog <= wdog + TW'(1);
            else        wdog <= '0;
            if (miscmp) begin
                if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
                if (err_cnt == '0) first_err_addr <= exp_addr;
                fail <= 1'b1;
            end
            if (wd_hit) fail <= 1'b1;
            if (busy && (state_n == S_DONE)) pass <= ~(fail | miscmp | wd_hit);
        end
    end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl with a RAM/read-latency model and
// immediate-assertion checks.
module tb_mem_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] tst_patt;
    logic [23:0] base_addr, num_words;
    logic        wr_en, wr_rdy, rd_en, rd_rdy, rd_data_valid;
    logic [23:0] wr_addr, rd_addr, first_err_addr;
    logic [31:0] wr_data, rd_data;
    logic        busy, done, pass, fail;
    logic [15:0] err_cnt;

    always #4 clk = ~clk;

    mem_bist_ctrl #(
        .DATA_W(32), .ADDR_W(24), .CMP_MASK(32'h00FFFFFF),
        .MAX_OUTST(8), .TIMEOUT(1024), .ERR_W(16)
    ) dut (
        .CLOCK_125_p(clk), .reset(rst_n), .start(start), .mode(mode),
        .tst_patt(tst_patt), .base_addr(base_addr), .num_words(num_words),
        .wr_en(wr_en), .wr_rdy(wr_rdy), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_rdy(rd_rdy), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid), .busy(busy), .done(done),
        .pass(pass), .fail(fail), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr)
    );

    logic [31:0] mem [logic [23:0]];
    logic [23:0] rq_addr [$];
    int          rq_due [$];
    int          cyc = 0, n_wr = 0, n_rd = 0, resp_idx = 0, drop_idx = 0;
    int          last_valid_edge = 0, tb_outst = 0, max_outst = 0;
    int          n_vec = 0, n_err = 0;
    bit          stall_en = 0, slow_resp = 0, corrupt_en = 0;
    logic [23:0] corrupt_addr = '0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RAM model: record accepted beats at the edge, answer reads next cycle.
    initial begin
        logic [23:0] a;
        logic [31:0] d;
        wr_rdy = 1'b1;
        rd_rdy = 1'b1;
        rd_data_valid = 1'b0;
        rd_data = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst_n) begin
                if (wr_en && wr_rdy) begin
                    mem[wr_addr] = wr_data;
                    n_wr++;
                end
                if (rd_data_valid && busy) tb_outst--;
                if (rd_en && rd_rdy) begin
                    rq_addr.push_back(rd_addr);
                    rq_due.push_back(cyc + 1);
                    n_rd++;
                    tb_outst++;
                end
                if (tb_outst > max_outst) max_outst = tb_outst;
            end
            @(negedge clk);
            rd_data_valid = 1'b0;
            rd_data = '0;
            if (rq_addr.size() > 0 && rq_due[0] <= cyc
                && (!slow_resp || $urandom_range(0, 3) == 0)) begin
                a = rq_addr.pop_front();
                void'(rq_due.pop_front());
                resp_idx++;
                if (resp_idx != drop_idx) begin
                    d = mem.exists(a) ? mem[a] : 32'h0;
                    if (corrupt_en && a == corrupt_addr) d[0] = ~d[0];
                    rd_data = d;
                    rd_data_valid = 1'b1;
                    last_valid_edge = cyc + 1;
                end
            end
            wr_rdy = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            rd_rdy = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic launch(input logic [1:0] m, input logic [31:0] p,
                          input logic [23:0] b, input logic [23:0] n);
        @(negedge clk);
        n_wr = 0; n_rd = 0; resp_idx = 0; tb_outst = 0; max_outst = 0;
        rq_addr.delete(); rq_due.delete(); mem.delete();
        mode = m; tst_patt = p; base_addr = b; num_words = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        start = 0; mode = 0; tst_patt = 0; base_addr = 0; num_words = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_flags", {busy, done, pass, fail, wr_en, rd_en}, 0);
        check("rst_addr", {wr_addr, rd_addr, first_err_addr}, 0);
        check("rst_data", {wr_data, err_cnt}, 0);
        rst_n = 1'b1;

        // T1 constant pattern
        launch(2'd0, 32'h00FFFFFF, 24'h0, 24'd8);
        wait_done(500, ok);
        check("T1_done", ok, 1);
        check("T1_pass_fail", {pass, fail}, 2'b10);
        check("T1_err", err_cnt, 0);
        check("T1_nwr_nrd", {n_wr[15:0], n_rd[15:0]}, {16'd8, 16'd8});
        check("T1_mem5", mem[24'h5], 32'h00FFFFFF);

        // T2 address pattern across the wrap, bit0 corrupted at addr 2
        corrupt_en = 1; corrupt_addr = 24'h2;
        launch(2'd1, 32'h0, 24'hFFFFFC, 24'd8);
        wait_done(500, ok);
        corrupt_en = 0;
        check("T2_done", ok, 1);
        check("T2_pass_fail", {pass, fail}, 2'b01);
        check("T2_err", err_cnt, 1);
        check("T2_first", first_err_addr, 24'h2);
        check("T2_memFFFFFD", mem[24'hFFFFFD], 32'h00FFFFFD);

        // T3 walk-1 with random stalls on all handshakes
        stall_en = 1; slow_resp = 1;
        launch(2'd2, 32'h0, 24'h100, 24'd40);
        wait_done(5000, ok);
        stall_en = 0; slow_resp = 0;
        check("T3_done", ok, 1);
        check("T3_pass_fail", {pass, fail}, 2'b10);
        check("T3_nwr", n_wr, 40);
        check("T3_word0", mem[24'h100], 32'h1);
        check("T3_word31", mem[24'h11F], 32'h80000000);
        check("T3_word33", mem[24'h121], 32'h2);
        check("T3_outst_le_max", (max_outst <= 8), 1);

        // T4 fifth response lost -> watchdog
        drop_idx = 5;
        launch(2'd0, 32'hA5A5A5A5, 24'h200, 24'd8);
        wait_done(3000, ok);
        drop_idx = 0;
        check("T4_done", ok, 1);
        check("T4_pass_fail", {pass, fail}, 2'b01);
        check("T4_err", err_cnt, 0);
        check("T4_latency", cyc - last_valid_edge, 1024);

        // T5 empty window, then start while busy
        launch(2'd1, 32'h0, 24'h30, 24'd0);
        check("T5_n0_done_pass", {done, pass, busy}, 3'b110);
        check("T5_n0_nwr_nrd", {n_wr[15:0], n_rd[15:0]}, 0);
        launch(2'd3, 32'h0, 24'h10, 24'd4);
        mode = 2'd0; num_words = 24'd2; base_addr = 24'h80; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(500, ok);
        check("T5_busy_done", ok, 1);
        check("T5_busy_pass", {pass, fail}, 2'b10);
        check("T5_busy_nwr", n_wr, 4);
        check("T5_mode3_word", mem[24'h12], 32'hFFFFFFED);

        // T6 asynchronous reset during the read phase
        launch(2'd1, 32'h0, 24'h40, 24'd16);
        for (int i = 0; i < 200 && n_rd < 3; i++) @(negedge clk);
        check("T6_in_read", (n_rd >= 3), 1);
        rst_n = 1'b0;
        #1;
        check("T6_rst_flags", {busy, done, pass, fail, wr_en, rd_en}, 0);
        check("T6_rst_addr", {wr_addr, rd_addr, first_err_addr}, 0);
        check("T6_rst_data", {wr_data, err_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        launch(2'd1, 32'h0, 24'h40, 24'd16);
        wait_done(500, ok);
        check("T6_done", ok, 1);
        check("T6_pass_fail", {pass, fail}, 2'b10);
        check("T6_nrd", n_rd, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
